// File: rtl/ss_seq_if.sv
// ss_seq_if
// Groups the save-state sequencer's datapath signals into one bundle:
//   - the mapper save-state bus (ss_act, ss_addr, ss_oe, ss_we, ss_wdat, ss_rdat)
//   - the dump byte stream   (dout, dout_vld, dout_rdy)
//   - the restore byte stream (din, din_vld, din_rdy)
// Modports:
//   master : the sequencer side (drives the mapper bus and the dump stream,
//            consumes the restore stream)
//   slave  : the mapper / host-FIFO side
interface ss_seq_if #(
   parameter int AW = 8
);
   logic          ss_act;
   logic [AW-1:0] ss_addr;
   logic          ss_oe;
   logic          ss_we;
   logic [7:0]    ss_wdat;
   logic [7:0]    ss_rdat;
   logic [7:0]    dout;
   logic          dout_vld;
   logic          dout_rdy;
   logic [7:0]    din;
   logic          din_vld;
   logic          din_rdy;

   modport master (
      output ss_act, ss_addr, ss_oe, ss_we, ss_wdat,
      input  ss_rdat,
      output dout, dout_vld,
      input  dout_rdy,
      input  din, din_vld,
      output din_rdy
   );

   modport slave (
      input  ss_act, ss_addr, ss_oe, ss_we, ss_wdat,
      output ss_rdat,
      input  dout, dout_vld,
      output dout_rdy,
      output din, din_vld,
      input  din_rdy
   );
endinterface

// File: rtl/ss_seq.sv
// ss_seq
// Save-state sequencer: initiator side of the mapper save-state port.
// On a host command it freezes the active mapper (ss_act) and walks its
// save-state register space, either dumping bytes out to a stream or
// restoring bytes from a stream back into the mapper.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : one-cycle command strobe, honoured only when idle
//   dir        : 0 = dump, 1 = restore (sampled with start)
//   len        : byte count, 0 means 2^AW (sampled with start)
//   abort      : terminate the current operation
//   busy       : high from accepted start until done
//   done       : one-cycle completion / abort pulse
//   bus        : ss_seq_if master modport (mapper bus + dump/restore streams)
module ss_seq #(
   parameter int AW     = 8,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          dir,
   input  logic [AW-1:0] len,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   ss_seq_if.master      bus
);

   localparam logic [2:0] LAT = 3'(RD_LAT);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      RD_OUT,
      WR_IN,
      WR_STB,
      FINISH
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW:0]   remain;
   logic [AW-1:0] addr;
   logic [2:0]    wait_cnt;
   logic [7:0]    dout_r;
   logic [7:0]    wdat_r;

   logic          load_cmd;
   logic          capture;
   logic          take;
   logic          step;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus the datapath event strobes.
   // Abort always wins over a handshake in the same cycle, so an unconsumed
   // dump byte or a pending restore byte is simply dropped.
   always_comb begin
      state_nxt = state;
      load_cmd  = 1'b0;
      capture   = 1'b0;
      take      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_cmd  = 1'b1;
               state_nxt = dir ? WR_IN : RD_REQ;
            end
         end
         RD_REQ: begin
            state_nxt = abort ? FINISH : RD_WAIT;
         end
         RD_WAIT: begin
            if (abort) begin
               state_nxt = FINISH;
            end else if (wait_cnt == 3'd1) begin
               capture   = 1'b1;
               state_nxt = RD_OUT;
            end
         end
         RD_OUT: begin
            if (abort) begin
               state_nxt = FINISH;
            end else if (bus.dout_rdy) begin
               step      = 1'b1;
               state_nxt = (remain == (AW+1)'(1)) ? FINISH : RD_REQ;
            end
         end
         WR_IN: begin
            if (abort) begin
               state_nxt = FINISH;
            end else if (bus.din_vld) begin
               take      = 1'b1;
               state_nxt = WR_STB;
            end
         end
         WR_STB: begin
            if (abort) begin
               state_nxt = FINISH;
            end else begin
               step      = 1'b1;
               state_nxt = (remain == (AW+1)'(1)) ? FINISH : WR_IN;
            end
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: address, remaining count, read-latency counter and data latches.
   // The wait counter is loaded with RD_LAT during the read strobe and the
   // byte is captured on the edge where it would reach zero, so ss_rdat is
   // sampled exactly RD_LAT cycles after ss_oe.
   // A len of 0 becomes 2^AW simply by placing the zero flag in the top bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         remain   <= '0;
         addr     <= '0;
         wait_cnt <= '0;
         dout_r   <= '0;
         wdat_r   <= '0;
      end else begin
         if (load_cmd) begin
            addr   <= '0;
            remain <= {(len == '0), len};
         end
         if (state == RD_REQ) begin
            wait_cnt <= LAT;
         end else if (state == RD_WAIT) begin
            wait_cnt <= wait_cnt - 3'd1;
         end
         if (capture) begin
            dout_r <= bus.ss_rdat;
         end
         if (take) begin
            wdat_r <= bus.din;
         end
         if (step) begin
            addr   <= addr + AW'(1);
            remain <= remain - (AW+1)'(1);
         end
      end
   end

   // Strobes and handshake flags decode straight from the state register, so
   // they are glitch-free and all drop to zero together on reset.
   assign busy         = (state != IDLE) && (state != FINISH);
   assign done         = (state == FINISH);
   assign bus.ss_act   = busy;
   assign bus.ss_addr  = addr;
   assign bus.ss_oe    = (state == RD_REQ);
   assign bus.ss_we    = (state == WR_STB);
   assign bus.ss_wdat  = wdat_r;
   assign bus.dout     = dout_r;
   assign bus.dout_vld = (state == RD_OUT);
   assign bus.din_rdy  = (state == WR_IN);

endmodule

// File: tb/tb_ss_seq.sv
// tb_ss_seq
// Directed self-checking bench for ss_seq. A small mapper model answers
// reads with addr^0xA5 exactly RD_LAT cycles after ss_oe; a negedge monitor
// records strobes, stream handshakes and done pulses for the scenarios.
module tb_ss_seq;

   localparam int AW     = 8;
   localparam int RD_LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          dir;
   logic [AW-1:0] len;
   logic          abort;
   logic          busy;
   logic          done;

   int vec_cnt = 0;
   int err_cnt = 0;

   ss_seq_if #(.AW(AW)) bus ();

   ss_seq #(.AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .dir   (dir),
      .len   (len),
      .abort (abort),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Mapper model: a read strobe at cycle t presents addr^0xA5 on ss_rdat
   // during cycle t+RD_LAT only; every other cycle shows filler 0xEE.
   logic [7:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= bus.ss_oe ? (bus.ss_addr ^ 8'hA5) : 8'hEE;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.ss_rdat = rd_pipe[RD_LAT-1];

   // Monitor state, cleared through mon_clr between scenarios
   logic       mon_clr = 1'b0;
   int         cycle = 0;
   int         oe_cnt, we_cnt, done_cnt, hs_cnt;
   int         clash_cnt, act_err_cnt, rdy_err_cnt;
   int         first_hs_cyc, last_hs_cyc, last_we_cyc, done_cyc;
   logic [7:0] oe_addr_q [$];
   logic [7:0] we_addr_q [$];
   logic [7:0] we_data_q [$];
   logic [7:0] dout_q    [$];

   always @(negedge clk) begin
      cycle <= cycle + 1;
      if (mon_clr) begin
         oe_cnt <= 0; we_cnt <= 0; done_cnt <= 0; hs_cnt <= 0;
         clash_cnt <= 0; act_err_cnt <= 0; rdy_err_cnt <= 0;
         first_hs_cyc <= 0; last_hs_cyc <= 0; last_we_cyc <= 0; done_cyc <= 0;
         oe_addr_q.delete(); we_addr_q.delete(); we_data_q.delete(); dout_q.delete();
      end else begin
         if (bus.ss_oe) begin
            oe_cnt <= oe_cnt + 1;
            oe_addr_q.push_back(bus.ss_addr);
         end
         if (bus.ss_we) begin
            we_cnt <= we_cnt + 1;
            last_we_cyc <= cycle;
            we_addr_q.push_back(bus.ss_addr);
            we_data_q.push_back(bus.ss_wdat);
         end
         if (bus.dout_vld && bus.dout_rdy) begin
            if (hs_cnt == 0) first_hs_cyc <= cycle;
            hs_cnt <= hs_cnt + 1;
            last_hs_cyc <= cycle;
            dout_q.push_back(bus.dout);
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cycle;
         end
         if (bus.ss_oe && bus.ss_we) clash_cnt <= clash_cnt + 1;
         if (busy != bus.ss_act) act_err_cnt <= act_err_cnt + 1;
         if (bus.ss_we && bus.din_rdy) rdy_err_cnt <= rdy_err_cnt + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] packq(input logic [7:0] q [$], input int n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r = {r[23:0], (i < q.size()) ? q[i] : 8'hFF};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearMon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
      tick();
   endtask

   task automatic applyStimulus(input logic d, input logic [AW-1:0] l);
      start = 1'b1;
      dir   = d;
      len   = l;
      tick();
      start = 1'b0;
      dir   = 1'b0;
      len   = '0;
   endtask

   task automatic waitDone(input int prev, input int limit, input string tag);
      int k;
      k = 0;
      while (done_cnt == prev && k < limit) begin
         tick();
         k++;
      end
      checkOutput({tag, " done seen"}, 32'(done_cnt != prev), 32'd1);
   endtask

   task automatic sendByte(input logic [7:0] d, input int gap);
      int k;
      repeat (gap) tick();
      bus.din     = d;
      bus.din_vld = 1'b1;
      k = 0;
      while (!bus.din_rdy && k < 50) begin
         tick();
         k++;
      end
      checkOutput("din_rdy seen", 32'(bus.din_rdy), 32'd1);
      tick();
      bus.din_vld = 1'b0;
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " done"}, 32'(done), 32'd0);
      checkOutput({tag, " bus flags"},
                  32'({bus.ss_act, bus.ss_oe, bus.ss_we, bus.dout_vld, bus.din_rdy}), 32'd0);
      checkOutput({tag, " ss_addr"}, 32'(bus.ss_addr), 32'd0);
   endtask

   task automatic restore3(input string tag);
      clearMon();
      applyStimulus(1'b1, 8'd3);
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      sendByte(8'h11, 0);
      sendByte(8'h22, 2);
      sendByte(8'h33, 0);
      waitDone(0, 20, tag);
      checkOutput({tag, " we count"}, 32'(we_cnt), 32'd3);
      checkOutput({tag, " we addrs"}, packq(we_addr_q, 3), 32'h00_00_01_02);
      checkOutput({tag, " we data"}, packq(we_data_q, 3), 32'h00_11_22_33);
      checkOutput({tag, " din_rdy in stb"}, 32'(rdy_err_cnt), 32'd0);
      checkOutput({tag, " done latency"}, 32'(done_cyc - last_we_cyc), 32'd1);
      checkOutput({tag, " busy after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k;
      int mism;
      logic stable;

      rst_n = 1'b0; start = 1'b0; dir = 1'b0; len = '0; abort = 1'b0;
      bus.dout_rdy = 1'b0; bus.din = '0; bus.din_vld = 1'b0;
      tick();
      tick();
      checkIdleZero("reset");
      checkOutput("reset dout", 32'(bus.dout), 32'd0);
      rst_n = 1'b1;
      tick();

      // Abort while idle must be ignored
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("idle abort busy", 32'(busy), 32'd0);
      checkOutput("idle abort done", 32'(done), 32'd0);

      // Scenario 1: dump of 4 bytes, always ready
      clearMon();
      bus.dout_rdy = 1'b1;
      applyStimulus(1'b0, 8'd4);
      checkOutput("s1 busy", 32'(busy), 32'd1);
      checkOutput("s1 ss_act", 32'(bus.ss_act), 32'd1);
      waitDone(0, 100, "s1");
      checkOutput("s1 stream", packq(dout_q, 4), 32'hA5_A4_A7_A6);
      checkOutput("s1 oe count", 32'(oe_cnt), 32'd4);
      checkOutput("s1 oe addrs", packq(oe_addr_q, 4), 32'h00_01_02_03);
      checkOutput("s1 done latency", 32'(done_cyc - last_hs_cyc), 32'd1);
      checkOutput("s1 throughput", 32'(last_hs_cyc - first_hs_cyc), 32'd12);
      checkOutput("s1 ss_act", 32'(act_err_cnt), 32'd0);
      checkOutput("s1 strobe clash", 32'(clash_cnt), 32'd0);
      tick();
      checkOutput("s1 done width", 32'(done), 32'd0);

      // Scenario 2: restore of 3 bytes with a gap before the second
      restore3("s2");

      // Scenario 3: dump of 2 with the first byte back-pressured; a start
      // issued mid-operation must be ignored
      clearMon();
      bus.dout_rdy = 1'b0;
      applyStimulus(1'b0, 8'd2);
      k = 0;
      while (!bus.dout_vld && k < 20) begin
         tick();
         k++;
      end
      checkOutput("s3 vld seen", 32'(bus.dout_vld), 32'd1);
      stable = 1'b1;
      start = 1'b1; dir = 1'b1; len = 8'd5;
      for (int i = 0; i < 5; i++) begin
         tick();
         start = 1'b0; dir = 1'b0; len = '0;
         stable = stable & (bus.dout_vld === 1'b1) & (bus.dout === 8'hA5);
      end
      checkOutput("s3 held stable", 32'(stable), 32'd1);
      checkOutput("s3 oe while held", 32'(oe_cnt), 32'd1);
      checkOutput("s3 no writes", 32'(we_cnt), 32'd0);
      bus.dout_rdy = 1'b1;
      waitDone(0, 40, "s3");
      checkOutput("s3 oe count", 32'(oe_cnt), 32'd2);
      checkOutput("s3 stream", packq(dout_q, 2), 32'h0000_A5A4);

      // Scenario 4: len=0 dumps the whole 256-byte space
      clearMon();
      bus.dout_rdy = 1'b1;
      applyStimulus(1'b0, 8'd0);
      waitDone(0, 1200, "s4");
      checkOutput("s4 oe count", 32'(oe_cnt), 32'd256);
      checkOutput("s4 hs count", 32'(hs_cnt), 32'd256);
      mism = 0;
      for (int i = 0; i < dout_q.size(); i++) begin
         if (dout_q[i] !== (8'(i) ^ 8'hA5)) mism++;
      end
      for (int i = 0; i < oe_addr_q.size(); i++) begin
         if (oe_addr_q[i] !== 8'(i)) mism++;
      end
      checkOutput("s4 data/addr errors", 32'(mism), 32'd0);
      checkOutput("s4 addr wrapped", 32'(bus.ss_addr), 32'd0);

      // Scenario 5: abort during the read wait of byte 1 of an 8-byte dump
      clearMon();
      bus.dout_rdy = 1'b1;
      applyStimulus(1'b0, 8'd8);
      k = 0;
      while (oe_cnt < 2 && k < 40) begin
         tick();
         k++;
      end
      checkOutput("s5 reached byte 1", 32'(oe_cnt), 32'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("s5 dout_vld dropped", 32'(bus.dout_vld), 32'd0);
      waitDone(0, 2, "s5");
      repeat (5) tick();
      checkOutput("s5 oe total", 32'(oe_cnt), 32'd2);
      checkOutput("s5 bytes out", 32'(hs_cnt), 32'd1);
      checkOutput("s5 busy after", 32'(busy), 32'd0);
      // Restart with abort held high alongside start: start must win
      clearMon();
      abort = 1'b1;
      applyStimulus(1'b0, 8'd1);
      abort = 1'b0;
      checkOutput("s5 restart busy", 32'(busy), 32'd1);
      waitDone(0, 20, "s5 restart");
      checkOutput("s5 restart byte", packq(dout_q, 1), 32'h0000_00A5);

      // Scenario 6: reset in the middle of a restore
      clearMon();
      applyStimulus(1'b1, 8'd3);
      sendByte(8'h11, 0);
      tick();
      checkOutput("s6 one write", 32'(we_cnt), 32'd1);
      rst_n = 1'b0;
      tick();
      checkIdleZero("s6 reset");
      checkOutput("s6 wdat cleared", 32'(bus.ss_wdat), 32'd0);
      rst_n = 1'b1;
      repeat (5) tick();
      checkOutput("s6 no done", 32'(done_cnt), 32'd0);
      checkOutput("s6 no more writes", 32'(we_cnt), 32'd1);
      restore3("s6 redo");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
